// File: rtl/mag_arbiter_pkg.sv
// mag_arbiter_pkg: shared types and sizing helpers for the magnitude arbiter.
//   state_t   : arbiter FSM states (IDLE, LOAD, CALC, DONE)
//   ITER      : restoring sqrt iterations for the default width (W+1)
//   SUM_W     : sum-of-squares width for the default width (2W+1)
//   iter_of / sum_w_of : the same quantities for an arbitrary W
package mag_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int W_DEFAULT = 8;
  localparam int ITER      = W_DEFAULT + 1;
  localparam int SUM_W     = 2 * W_DEFAULT + 1;

  function automatic int iter_of(input int w);
    return w + 1;
  endfunction

  function automatic int sum_w_of(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/isqrt_core.sv
// isqrt_core: iterative restoring integer square root, one result bit per cycle.
//   clk, rst : clock, async active-high reset
//   start    : load op and begin; takes priority over a running operation
//   op       : radicand, 2W+1 bits
//   done     : high from the cycle after the last iteration until the next start
//   root     : floor(sqrt(op)), W+1 bits, valid while done is high
module isqrt_core
  import mag_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [sum_w_of(W)-1:0]   op,
  output logic                     done,
  output logic [W:0]               root
);

  localparam int IT    = iter_of(W);
  localparam int SW    = sum_w_of(W);
  localparam int RAD_W = 2 * IT;          // padded to an even bit count
  localparam int REM_W = W + 4;           // partial remainder <= 2*root, plus 2 shifted-in bits
  localparam int CNT_W = $clog2(IT + 1);

  logic [RAD_W-1:0] rad;
  logic [REM_W-1:0] rem, rem_sh, trial;
  logic [W:0]       root_q;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             ge;

  // Bring down the next two radicand bits and try subtracting 4*root+1.
  assign rem_sh = {rem[REM_W-3:0], rad[RAD_W-1 -: 2]};
  assign trial  = {{(REM_W-W-3){1'b0}}, root_q, 2'b01};
  assign ge     = (rem_sh >= trial);
  assign root   = root_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad    <= '0;
      rem    <= '0;
      root_q <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (start) begin
      rad    <= {{(RAD_W-SW){1'b0}}, op};
      rem    <= '0;
      root_q <= '0;
      cnt    <= CNT_W'(IT);
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (busy) begin
      rad    <= {rad[RAD_W-3:0], 2'b00};
      rem    <= ge ? (rem_sh - trial) : rem_sh;
      root_q <= {root_q[W-1:0], ge};
      cnt    <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mag_arbiter.sv
// mag_arbiter: two requesters share one gradient-magnitude engine,
// result = floor(sqrt(gx^2 + gy^2)), round-robin arbitration.
//   clk, rst                 : clock, async active-high reset
//   req_valid[1:0]           : request valid per requester
//   req_ready[1:0]           : one-hot grant, only in IDLE
//   req0_gx/gy, req1_gx/gy   : unsigned W-bit gradient pairs
//   rsp_valid / rsp_ready    : result handshake, result held until accepted
//   rsp_id                   : requester that owns the result
//   rsp_data                 : magnitude, W bits
// Build option: MAG_ARBITER_SAT_EN saturates roots above 2^W-1; otherwise
// the low W bits of the root are returned.
// Latency: accept edge -> LOAD -> 1 core start + W+1 iterations -> DONE,
// rsp_valid rises W+3 cycles after accept.
module mag_arbiter
  import mag_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req0_gx,
  input  logic [W-1:0] req0_gy,
  input  logic [W-1:0] req1_gx,
  input  logic [W-1:0] req1_gy,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data
);

  localparam int SW = sum_w_of(W);

`ifdef MAG_ARBITER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  state_t         state;
  logic           ptr;        // requester that wins a tie
  logic           id_q;
  logic [W-1:0]   gx_q, gy_q;
  logic [1:0]     grant;
  logic [2*W-1:0] sqx, sqy;
  logic [SW-1:0]  sum;
  logic           core_done;
  logic [W:0]     root;
  logic [W-1:0]   res;

  // Grant is gated by rst so req_ready stays low for the whole reset pulse.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE && !rst) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;

  // Sum of squares from the captured operands; the core registers it in LOAD.
  assign sqx = {{W{1'b0}}, gx_q} * {{W{1'b0}}, gx_q};
  assign sqy = {{W{1'b0}}, gy_q} * {{W{1'b0}}, gy_q};
  assign sum = {1'b0, sqx} + {1'b0, sqy};

  isqrt_core #(.W(W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (state == LOAD),
    .op    (sum),
    .done  (core_done),
    .root  (root)
  );

  assign res = (SAT && root[W]) ? {W{1'b1}} : root[W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      id_q      <= 1'b0;
      gx_q      <= '0;
      gy_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: if (|grant) begin
          gx_q  <= grant[1] ? req1_gx : req0_gx;
          gy_q  <= grant[1] ? req1_gy : req0_gy;
          id_q  <= grant[1];
          ptr   <= ~grant[1];
          state <= LOAD;
        end
        LOAD: state <= CALC;
        CALC: if (core_done) begin
          rsp_data  <= res;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
